// File: rtl/data_uncache_unit.sv
// Uncached load/store engine behind the data MMU: posts stores through a small
// write buffer and issues strictly ordered single-beat AXI3 reads.
module data_uncache_unit #(
  parameter int WB_DEPTH = 4,
  parameter int WB_PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  input  logic                req_wr_i,
  input  logic [11:0]         req_offset_i,
  input  logic [1:0]          req_size_i,
  input  logic [3:0]          req_wstrb_i,
  input  logic [31:0]         req_wdata_i,
  input  logic [19:0]         data_tag_i,
  input  logic                data_unCache_i,
  input  logic                data_hasException_i,
  output logic                stall_o,
  output logic                data_ok_o,
  output logic [31:0]         rdata_o,
  output logic                arvalid_o,
  output logic [31:0]         araddr_o,
  output logic [2:0]          arsize_o,
  input  logic                arready_i,
  input  logic                rvalid_i,
  input  logic [31:0]         rdata_i,
  output logic                rready_o,
  output logic                awvalid_o,
  output logic [31:0]         awaddr_o,
  output logic [2:0]          awsize_o,
  input  logic                awready_i,
  output logic                wvalid_o,
  output logic [31:0]         wdata_o,
  output logic [3:0]          wstrb_o,
  output logic                wlast_o,
  input  logic                wready_i,
  input  logic                bvalid_i,
  output logic                bready_o
);

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  typedef enum logic [2:0] {R_IDLE, R_DRAIN, R_AR, R_R, R_DONE} r_state_t;

  localparam logic [WB_PTR_W:0] FULL_COUNT = (WB_PTR_W + 1)'(WB_DEPTH);

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic [WB_PTR_W:0]   count_reg, count_next;
  logic [WB_PTR_W-1:0] head_reg, tail_reg;
  logic                aw_done_reg, w_done_reg;
  logic                store_ok_reg;
  logic [31:0]         ld_addr_reg;
  logic [1:0]          ld_size_reg;
  logic [31:0]         rdata_reg;

  logic [31:0] fifo_addr [WB_DEPTH];
  logic [1:0]  fifo_size [WB_DEPTH];
  logic [3:0]  fifo_strb [WB_DEPTH];
  logic [31:0] fifo_data [WB_DEPTH];

  logic        acc;
  logic [31:0] req_addr;
  logic        wb_full;
  logic        push;
  logic        pop;
  logic        load_accept;
  logic        aw_fire;
  logic        w_fire;
  logic        r_fire;

  assign acc         = req_valid_i & data_unCache_i & ~data_hasException_i;
  assign req_addr    = {data_tag_i, req_offset_i};
  assign wb_full     = (count_reg == FULL_COUNT);
  // Full is judged on the registered count only, so a same-cycle pop never admits a push.
  assign push        = acc & req_wr_i & ~wb_full & (r_state_reg == R_IDLE);
  assign load_accept = acc & ~req_wr_i & (r_state_reg == R_IDLE);
  assign aw_fire     = awvalid_o & awready_i;
  assign w_fire      = wvalid_o & wready_i;
  assign pop         = bready_o & bvalid_i;
  assign r_fire      = rready_o & rvalid_i;

  // ---------------- write buffer ----------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail_reg] <= req_addr;
      fifo_size[tail_reg] <= req_size_i;
      fifo_strb[tail_reg] <= req_wstrb_i;
      fifo_data[tail_reg] <= req_wdata_i;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      store_ok_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      store_ok_reg <= push;
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
    end
  end

  // ---------------- drain FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state_reg <= W_IDLE;
    else      w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE: if (count_reg != '0) w_state_next = W_SEND;
      W_SEND: if ((aw_done_reg | aw_fire) & (w_done_reg | w_fire)) w_state_next = W_RESP;
      W_RESP: if (bvalid_i) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    awvalid_o = (w_state_reg == W_SEND) & ~aw_done_reg;
    wvalid_o  = (w_state_reg == W_SEND) & ~w_done_reg;
    bready_o  = (w_state_reg == W_RESP);
  end

  // AW and W complete independently; each flag remembers its own handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else if (w_state_reg != W_SEND) begin
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      if (aw_fire) aw_done_reg <= 1'b1;
      if (w_fire)  w_done_reg  <= 1'b1;
    end
  end

  assign awaddr_o = fifo_addr[head_reg];
  assign awsize_o = {1'b0, fifo_size[head_reg]};
  assign wdata_o  = fifo_data[head_reg];
  assign wstrb_o  = fifo_strb[head_reg];
  assign wlast_o  = wvalid_o;

  // ---------------- load FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state_reg <= R_IDLE;
    else      r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (load_accept) r_state_next = R_DRAIN;
      R_DRAIN: if ((count_reg == '0) && (w_state_reg == W_IDLE)) r_state_next = R_AR;
      R_AR:    if (arready_i) r_state_next = R_R;
      R_R:     if (rvalid_i) r_state_next = R_DONE;
      R_DONE:  r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    arvalid_o = (r_state_reg == R_AR);
    rready_o  = (r_state_reg == R_R);
    data_ok_o = store_ok_reg | (r_state_reg == R_DONE);
    // Gated by rst so an incoming request cannot raise stall while in reset.
    stall_o   = rst & (load_accept
                       | (r_state_reg == R_DRAIN)
                       | (r_state_reg == R_AR)
                       | (r_state_reg == R_R)
                       | (acc & req_wr_i & wb_full));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_addr_reg <= '0;
      ld_size_reg <= '0;
      rdata_reg   <= '0;
    end else begin
      if (load_accept) begin
        ld_addr_reg <= req_addr;
        ld_size_reg <= req_size_i;
      end
      if (r_fire) rdata_reg <= rdata_i;
    end
  end

  assign araddr_o = ld_addr_reg;
  assign arsize_o = {1'b0, ld_size_reg};
  assign rdata_o  = rdata_reg;

endmodule
